// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types and constants for the fetch/data memory-port arbiter:
// bus width, FSM state encodings, owner ids and the fetch half-word select.
package mem_port_arbiter_pkg;

   localparam int WIDTH           = 64;
   localparam int STREAK_W        = 3;
   localparam int DATA_STREAK_DEF = 4;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   // Instruction word within the 8-byte memory word, chosen by address bit 2.
   function automatic logic [31:0] fetch_half(input logic [WIDTH-1:0] word,
                                              input logic             sel_hi);
      logic [31:0] res;
      if (sel_hi) begin
         res = word[63:32];
      end else begin
         res = word[31:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch requester, data requester and memory port signals.
//   slave  : arbiter view (takes requests, drives the memory port)
//   master : environment view (requesters and memory)
interface mem_port_arbiter_if;
   import mem_port_arbiter_pkg::*;

   logic             if_req;
   logic [WIDTH-1:0] if_addr;
   logic             if_kill;
   logic             if_gnt;
   logic             if_rvalid;
   logic [31:0]      if_rdata;

   logic             d_req;
   logic             d_we;
   logic [WIDTH-1:0] d_addr;
   logic [WIDTH-1:0] d_wdata;
   logic [7:0]       d_wmask;
   logic             d_gnt;
   logic             d_rvalid;
   logic [WIDTH-1:0] d_rdata;

   logic             m_req;
   logic             m_we;
   logic [WIDTH-1:0] m_addr;
   logic [WIDTH-1:0] m_wdata;
   logic [7:0]       m_wmask;
   logic             m_gnt;
   logic             m_rvalid;
   logic [WIDTH-1:0] m_rdata;

   modport slave (
      input  if_req, if_addr, if_kill,
      output if_gnt, if_rvalid, if_rdata,
      input  d_req, d_we, d_addr, d_wdata, d_wmask,
      output d_gnt, d_rvalid, d_rdata,
      output m_req, m_we, m_addr, m_wdata, m_wmask,
      input  m_gnt, m_rvalid, m_rdata
   );

   modport master (
      output if_req, if_addr, if_kill,
      input  if_gnt, if_rvalid, if_rdata,
      output d_req, d_we, d_addr, d_wdata, d_wmask,
      input  d_gnt, d_rvalid, d_rdata,
      input  m_req, m_we, m_addr, m_wdata, m_wmask,
      output m_gnt, m_rvalid, m_rdata
   );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick
// Combinational winner select between fetch and data requests.
//   if_req, d_req : pending requests
//   streak_full   : data has won the maximum number of times in a row
//   pick_if/pick_d: one-hot (or zero) winner
module arb_pick (
   input  logic if_req,
   input  logic d_req,
   input  logic streak_full,
   output logic pick_if,
   output logic pick_d
);

   // Data has priority unless the fetch has been starved long enough.
   always_comb begin
      pick_if = 1'b0;
      pick_d  = 1'b0;
      if (if_req && (!d_req || streak_full)) begin
         pick_if = 1'b1;
      end else if (d_req) begin
         pick_d = 1'b1;
      end else begin
         pick_if = 1'b0;
         pick_d  = 1'b0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between instruction fetch and data access.
// One transaction at a time: IDLE (grant) -> ISSUE (m_req until m_gnt)
// -> WAIT (until m_rvalid) -> IDLE, with a registered response pulse.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   bus              : fetch, data and memory signals (slave view)
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int DATA_STREAK = DATA_STREAK_DEF
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   mem_port_arbiter_if.slave    bus
);

   arb_state_e          state_q,     state_d;
   owner_e              owner_q,     owner_d;
   logic [STREAK_W-1:0] streak_q,    streak_d;
   logic                kill_q,      kill_d;
   logic                m_req_q,     m_req_d;
   logic                m_we_q,      m_we_d;
   logic [WIDTH-1:0]    m_addr_q,    m_addr_d;
   logic [WIDTH-1:0]    m_wdata_q,   m_wdata_d;
   logic [7:0]          m_wmask_q,   m_wmask_d;
   logic                if_rvalid_q, if_rvalid_d;
   logic [31:0]         if_rdata_q,  if_rdata_d;
   logic                d_rvalid_q,  d_rvalid_d;
   logic [WIDTH-1:0]    d_rdata_q,   d_rdata_d;

   logic pick_if;
   logic pick_d;
   logic streak_full;
   logic idle_s;
   logic fetch_owned;

   assign streak_full = (streak_q == STREAK_W'(DATA_STREAK));
   assign idle_s      = (state_q == ARB_IDLE) && !sys_rst;
   assign fetch_owned = (owner_q == OWN_IF);

   arb_pick u_pick (
      .if_req      (bus.if_req),
      .d_req       (bus.d_req),
      .streak_full (streak_full),
      .pick_if     (pick_if),
      .pick_d      (pick_d)
   );

   // Grants are only visible while the port is free.
   assign bus.if_gnt = idle_s && pick_if;
   assign bus.d_gnt  = idle_s && pick_d;

   assign bus.m_req     = m_req_q;
   assign bus.m_we      = m_we_q;
   assign bus.m_addr    = m_addr_q;
   assign bus.m_wdata   = m_wdata_q;
   assign bus.m_wmask   = m_wmask_q;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.d_rdata   = d_rdata_q;

   // Next-state logic for the FSM, payload, streak counter, kill and responses.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      streak_d    = streak_q;
      kill_d      = kill_q;
      m_req_d     = m_req_q;
      m_we_d      = m_we_q;
      m_addr_d    = m_addr_q;
      m_wdata_d   = m_wdata_q;
      m_wmask_d   = m_wmask_q;
      if_rvalid_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rvalid_d  = 1'b0;
      d_rdata_d   = d_rdata_q;

      case (state_q)
         ARB_IDLE: begin
            if (pick_if) begin
               owner_d   = OWN_IF;
               m_we_d    = 1'b0;
               m_addr_d  = bus.if_addr;
               m_wdata_d = {WIDTH{1'b0}};
               m_wmask_d = 8'h00;
               streak_d  = {STREAK_W{1'b0}};
               // A redirect in the grant cycle still grants but drops the answer.
               kill_d    = bus.if_kill;
               m_req_d   = 1'b1;
               state_d   = ARB_ISSUE;
            end else if (pick_d) begin
               owner_d   = OWN_D;
               m_we_d    = bus.d_we;
               m_addr_d  = bus.d_addr;
               m_wdata_d = bus.d_wdata;
               m_wmask_d = bus.d_wmask;
               kill_d    = 1'b0;
               m_req_d   = 1'b1;
               state_d   = ARB_ISSUE;
               // Count only grants that made a waiting fetch lose.
               if (!bus.if_req) begin
                  streak_d = {STREAK_W{1'b0}};
               end else if (!streak_full) begin
                  streak_d = streak_q + STREAK_W'(1);
               end else begin
                  streak_d = streak_q;
               end
            end else begin
               kill_d = 1'b0;
            end
         end
         ARB_ISSUE: begin
            if (fetch_owned && bus.if_kill) begin
               kill_d = 1'b1;
            end else begin
               kill_d = kill_q;
            end
            if (bus.m_gnt) begin
               m_req_d = 1'b0;
               state_d = ARB_WAIT;
            end else begin
               m_req_d = 1'b1;
            end
         end
         ARB_WAIT: begin
            if (fetch_owned && bus.if_kill) begin
               kill_d = 1'b1;
            end else begin
               kill_d = kill_q;
            end
            if (bus.m_rvalid) begin
               state_d = ARB_IDLE;
               kill_d  = 1'b0;
               if (!fetch_owned) begin
                  d_rvalid_d = 1'b1;
                  d_rdata_d  = bus.m_rdata;
               end else if (!(kill_q || bus.if_kill)) begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = fetch_half(bus.m_rdata, m_addr_q[2]);
               end else begin
                  if_rvalid_d = 1'b0;
               end
            end else begin
               state_d = ARB_WAIT;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            m_req_d = 1'b0;
            kill_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= ARB_IDLE;
         owner_q     <= OWN_IF;
         streak_q    <= {STREAK_W{1'b0}};
         kill_q      <= 1'b0;
         m_req_q     <= 1'b0;
         m_we_q      <= 1'b0;
         m_addr_q    <= {WIDTH{1'b0}};
         m_wdata_q   <= {WIDTH{1'b0}};
         m_wmask_q   <= 8'h00;
         if_rvalid_q <= 1'b0;
         if_rdata_q  <= 32'h0000_0000;
         d_rvalid_q  <= 1'b0;
         d_rdata_q   <= {WIDTH{1'b0}};
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         streak_q    <= streak_d;
         kill_q      <= kill_d;
         m_req_q     <= m_req_d;
         m_we_q      <= m_we_d;
         m_addr_q    <= m_addr_d;
         m_wdata_q   <= m_wdata_d;
         m_wmask_q   <= m_wmask_d;
         if_rvalid_q <= if_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         d_rvalid_q  <= d_rvalid_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer that shares one memory port between the instruction-fetch path and the data-access path of the five-stage pipeline. It accepts one request at a time from each side, issues it on the memory port, waits for the response, and returns it to the owner. Data requests have priority; a streak counter bounds fetch starvation. A kill input drops an in-flight fetch response on PC redirect.

## Interface
- `DATA_STREAK`, 4: the maximum number of consecutive data grants while a fetch is pending; the next arbitration then favours the fetch.
- `sys_clk  in  1`  clock.
- `sys_rst  in  1`  reset. One clock; reset is synchronous and active-high.
- `if_req  in  1`  fetch request; held with `if_addr` until `if_gnt`.
- `if_addr  in  64`  fetch byte address, 4-byte aligned.
- `if_kill  in  1`  redirect; cancels the pending or in-flight fetch response.
- `if_gnt  out  1`  fetch request accepted this cycle.
- `if_rvalid  out  1`  fetch response pulse.
- `if_rdata  out  32`  instruction word.
- `d_req  in  1`  data request; held with its payload until `d_gnt`.
- `d_we  in  1`  store.
- `d_addr  in  64`  data address.
- `d_wdata  in  64`  store data.
- `d_wmask  in  8`  byte enables.
- `d_gnt  out  1`  data request accepted.
- `d_rvalid  out  1`  data response pulse (load data or store ack).
- `d_rdata  out  64`  load data.
- `m_req  out  1`  memory request.
- `m_we  out  1`  memory write.
- `m_addr  out  64`  memory address.
- `m_wdata  out  64`  memory write data.
- `m_wmask  out  8`  memory byte enables.
- `m_gnt  in  1`  memory accepted `m_req`.
- `m_rvalid  in  1`  memory response.
- `m_rdata  in  64`  memory read data, 8-byte aligned word.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE:**
  - Pick a winner from `if_req`/`d_req`.
  - Data wins, unless `streak == DATA_STREAK` and `if_req` is high; then fetch wins.
  - The winner's `*_gnt` is asserted combinationally in IDLE only.
  - The winner's payload and owner id are registered, then the FSM moves to ISSUE.
  - If no request is present, stay in IDLE.
- **ISSUE:** `m_req` = 1 with the registered payload. On `m_gnt`, go to WAIT. Otherwise hold `m_req` and the payload unchanged.
- **WAIT:** `m_req` = 0. On `m_rvalid`, capture `m_rdata` and go to IDLE. The next cycle pulses the owner's `*_rvalid`.
- **Fetch data:** `if_rdata = if_addr_q[2] ? word[63:32] : word[31:0]`.
- **Data response:** `d_rdata` = the full captured word. `d_rvalid` also pulses for stores; `d_rdata` is then the unchanged captured `m_rdata`.
- **Streak counter (3 bits minimum):**
  - Increments on a data grant while `if_req` is high.
  - Clears on a fetch grant, or on a data grant with `if_req` low.
  - Saturates at `DATA_STREAK`.
- **Kill:**
  - `if_kill` with fetch owning ISSUE/WAIT sets `kill_q`. The transaction still completes on the memory port; `if_rvalid` is suppressed.
  - `kill_q` clears on return to IDLE.
  - `if_kill` in IDLE has no effect on state.
  - `if_kill` in the same cycle as `if_gnt` still grants, and sets `kill_q`.
- **Stray responses:** `m_rvalid` in IDLE or ISSUE is ignored.

## Timing
- **Minimum latency:** request seen in cycle 0 (gnt), `m_req` in cycle 1, `m_gnt` in cycle 1, `m_rvalid` in cycle 2, `*_rvalid` in cycle 3.
- **Throughput:** at most one transaction per 3 cycles; no overlap.
- **Hold rules:** requesters must hold `*_req` and payload until `*_gnt`. Requesters must not drop `*_req` before `*_gnt`, except fetch on `if_kill`.
- **Reset (synchronous):** state = IDLE, `streak` = 0, `kill_q` = 0. `m_req`, `m_we`, `m_addr`, `m_wdata`, `m_wmask` = 0. Both `*_gnt` and `*_rvalid` = 0; `if_rdata` and `d_rdata` = 0.
- **Reset mid-transaction:** the transaction is abandoned; the owner gets no response; a later `m_rvalid` is ignored.
- **Pulse width:** `*_rvalid` are single-cycle registered pulses. `*_rdata` hold their value until the next response.

## Structure
- Shared header `para.v`:
  - `width` reused for address and data.
  - New `ARB_IDLE`/`ARB_ISSUE`/`ARB_WAIT` 2-bit encodings.
  - New `OWN_IF`/`OWN_D` owner ids.
- One sub-module, `arb_pick`: a combinational winner select from `if_req`, `d_req`, and `streak == DATA_STREAK`. The FSM, registers and counter stay in `mem_port_arbiter`.

## Test plan
- **Lone fetch:** `if_addr` = 0x8000_0004, memory returns 0x1111_2222_3333_4444 one cycle after `m_gnt` → `if_rvalid` in cycle 3 with `if_rdata` = 0x1111_2222.
- **Simultaneous requests:** `if_req` and `d_req` (load 0x100) in the same cycle → `d_gnt` first. The fetch is granted in the first IDLE after `d_rvalid`.
- **Starvation:** `d_req` held continuously with `if_req` high, `DATA_STREAK` = 4 → exactly 4 data grants, then one fetch grant, then `streak` = 0.
- **Kill during WAIT:** `if_kill` asserted during WAIT of a fetch → `m_rvalid` consumed, `if_rvalid` stays 0, the next request is granted normally.
- **Memory backpressure and store:** `m_gnt` low for 5 cycles, store with `d_wmask` = 0x0F → `m_req`/`m_addr`/`m_wdata` stable all 5 cycles. `d_rvalid` pulses once after `m_rvalid`.
- **Reset in WAIT:** `sys_rst` for 1 cycle during WAIT, then `m_rvalid` → no `*_rvalid`; all outputs 0; the next `d_req` is granted in the first IDLE cycle.
